mtr_drv: RTL and testbench

- Downstream neighbour of the heading PID stage. Consumes the signed 11-bit lft_spd/rght_spd commands.
- Produces two complementary PWM pairs, one per motor H-bridge, from a shared free-running 11-bit PWM counter.
- Each pair has a programmable non-overlap (dead) time so the high and low bridge legs never conduct together.
- Duty updates are applied only at the PWM period boundary, so duty never changes mid-period.

---
 rtl/mtr_drv.sv | 116 +++++++++++
 tb/tb_mtr_drv.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
//  Module      : mtr_drv
//  Description : Dual H-bridge PWM driver. A shared free-running 11-bit
//                counter makes one 2048-clk PWM period. Each channel has a
//                duty register that loads only at the period boundary, a
//                PWM comparator, and a non-overlap timer that inserts a dead
//                time after every edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module mtr_drv #(
  parameter int NONOVERLAP = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        pwm_synch
);

  localparam logic [10:0] c_CNT_MAX  = 11'h7FF;
  localparam logic [10:0] c_DUTY_RST = 11'h400;
  localparam logic [7:0]  c_NOVL     = 8'(NONOVERLAP);

  logic [10:0]      r_cnt;
  logic [1:0][10:0] w_spd;
  logic [1:0]       w_pwm1;
  logic [1:0]       w_pwm2;

  // Free-running period counter, wraps naturally at 0x7FF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 11'd1;
    end
  end

  // Last count of the period: the duty registers load on this edge.
  assign pwm_synch = (r_cnt == c_CNT_MAX);

  // Channel 0 is left, channel 1 is right.
  assign w_spd[0] = lft_spd;
  assign w_spd[1] = rght_spd;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_ch
      logic [10:0] r_duty;
      logic        r_sig;
      logic [7:0]  r_scnt;
      logic        r_pwm1;
      logic        r_pwm2;
      logic        w_sig_nxt;

      // Raw PWM level for the coming cycle.
      assign w_sig_nxt = (r_cnt < r_duty);

      // Duty load at the period boundary; inverting the MSB turns the
      // signed speed into an offset-binary duty (0x400 speed -> duty 0).
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_duty <= c_DUTY_RST;
        end else if (pwm_synch) begin
          r_duty <= w_spd[g] ^ c_DUTY_RST;
        end
      end

      // Registered PWM comparator output.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sig <= 1'b0;
        end else begin
          r_sig <= w_sig_nxt;
        end
      end

      // Stability timer: restarts on every PWM edge, saturates at the
      // dead time so a leg is enabled only once the level has settled.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_scnt <= '0;
        end else if (w_sig_nxt != r_sig) begin
          r_scnt <= '0;
        end else if (r_scnt < c_NOVL) begin
          r_scnt <= r_scnt + 8'd1;
        end
      end

      // Bridge legs: only the leg matching the settled level is driven,
      // so short pulses never reach either leg.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pwm1 <= 1'b0;
          r_pwm2 <= 1'b0;
        end else begin
          r_pwm1 <= r_sig & (r_scnt == c_NOVL);
          r_pwm2 <= ~r_sig & (r_scnt == c_NOVL);
        end
      end

      assign w_pwm1[g] = r_pwm1;
      assign w_pwm2[g] = r_pwm2;
    end
  endgenerate

  assign lftPWM1  = w_pwm1[0];
  assign lftPWM2  = w_pwm2[0];
  assign rghtPWM1 = w_pwm1[1];
  assign rghtPWM2 = w_pwm2[1];

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mtr_drv
//  Description : Directed self-checking bench for mtr_drv. Counts per-period
//                leg high times against hand-computed values and tracks
//                leg overlap and dead-time gaps continuously.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mtr_drv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] lft_spd;
  logic [10:0] rght_spd;
  logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, pwm_synch;

  int n_vec  = 0;
  int n_miss = 0;

  // Continuous monitor state (written only by the monitor block).
  int ovl     = 0;
  int run_l   = 0;
  int run_r   = 0;
  int gaps_l  = 0;
  int gaps_r  = 0;
  int g32_l   = 0;
  int g32_r   = 0;
  int min_gap = 1 << 30;

  always #5 clk = ~clk;

  mtr_drv #(.NONOVERLAP(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .lftPWM1  (lftPWM1),
    .lftPWM2  (lftPWM2),
    .rghtPWM1 (rghtPWM1),
    .rghtPWM2 (rghtPWM2),
    .pwm_synch(pwm_synch)
  );

  // Overlap and dead-time gap tracking, sampled on the falling edge.
  always @(negedge clk) begin
    if ((lftPWM1 & lftPWM2) | (rghtPWM1 & rghtPWM2)) ovl++;
    if (lftPWM1 | lftPWM2) begin
      if (run_l > 0) begin
        gaps_l++;
        if (run_l == 32) g32_l++;
        if (run_l < min_gap) min_gap = run_l;
      end
      run_l = 0;
    end else begin
      run_l++;
    end
    if (rghtPWM1 | rghtPWM2) begin
      if (run_r > 0) begin
        gaps_r++;
        if (run_r == 32) g32_r++;
        if (run_r < min_gap) min_gap = run_r;
      end
      run_r = 0;
    end else begin
      run_r++;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_synch();
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (pwm_synch) return;
    end
    chk("synch_timeout", 0, 1);
  endtask

  // One window of 2048 samples starting at cnt = 0 (call at the synch sample).
  task automatic measure(input int chg_at, input logic [10:0] chg_val,
                         output int p1l, output int p2l,
                         output int p1r, output int p2r, output int syn);
    p1l = 0; p2l = 0; p1r = 0; p2r = 0; syn = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (i == chg_at) lft_spd = chg_val;
      p1l += int'(lftPWM1);
      p2l += int'(lftPWM2);
      p1r += int'(rghtPWM1);
      p2r += int'(rghtPWM2);
      syn += int'(pwm_synch);
    end
  endtask

  // Bounded run time in case the sequencing goes astray.
  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p1l, p2l, p1r, p2r, syn, hi;
    int gl0, gr0, g32l0, g32r0;

    rst_n    = 1'b0;
    lft_spd  = 11'h000;
    rght_spd = 11'h000;
    repeat (3) @(negedge clk);
    chk("rst_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
    chk("rst_synch", int'(pwm_synch), 0);

    // Release: dead time, then 50% duty from the reset value.
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      hi += int'(lftPWM1 | lftPWM2 | rghtPWM1 | rghtPWM2);
    end
    chk("rel_dead", hi, 0);
    @(negedge clk);
    chk("rel_lp1", int'(lftPWM1), 1);
    chk("rel_rp1", int'(rghtPWM1), 1);
    wait_synch();

    // Speed 0 on both sides (duty 0x400), three full periods.
    #1;
    gl0 = gaps_l; gr0 = gaps_r; g32l0 = g32_l; g32r0 = g32_r;
    for (int p = 0; p < 3; p++) begin
      measure(-1, 11'h000, p1l, p2l, p1r, p2r, syn);
      chk("t1_lp1", p1l, 992);
      chk("t1_lp2", p2l, 992);
      chk("t1_rp1", p1r, 992);
      chk("t1_rp2", p2r, 992);
      chk("t1_synch", syn, 1);
    end
    #1;
    chk("t1_lgaps", gaps_l - gl0, 6);
    chk("t1_lg32", g32_l - g32l0, 6);
    chk("t1_rgaps", gaps_r - gr0, 6);
    chk("t1_rg32", g32_r - g32r0, 6);

    // Full forward left (duty 0x7FF), full reverse right (duty 0).
    lft_spd  = 11'h3FF;
    rght_spd = 11'h400;
    measure(-1, 11'h3FF, p1l, p2l, p1r, p2r, syn);
    measure(-1, 11'h3FF, p1l, p2l, p1r, p2r, syn);
    chk("t2_lp1", p1l, 2015);
    chk("t2_lp2", p2l, 0);
    chk("t2_rp1", p1r, 0);
    chk("t2_rp2", p2r, 2048);

    // Mid-period speed change must wait for the boundary.
    lft_spd = 11'h000;
    measure(-1, 11'h000, p1l, p2l, p1r, p2r, syn);
    measure(256, 11'h200, p1l, p2l, p1r, p2r, syn);
    chk("t3_cur_lp1", p1l, 992);
    chk("t3_cur_lp2", p2l, 992);
    measure(-1, 11'h200, p1l, p2l, p1r, p2r, syn);
    chk("t3_nxt_lp1", p1l, 1504);
    chk("t3_nxt_lp2", p2l, 480);

    // Pulse shorter than the dead time: forward leg suppressed.
    lft_spd = 11'h410;
    measure(-1, 11'h410, p1l, p2l, p1r, p2r, syn);
    #1;
    gl0 = gaps_l;
    measure(-1, 11'h410, p1l, p2l, p1r, p2r, syn);
    chk("t4_lp1", p1l, 0);
    chk("t4_lp2", p2l, 2000);
    chk("t4_rp2", p2r, 2048);
    #1;
    chk("t4_lgaps", gaps_l - gl0, 1);

    // Asynchronous reset in the middle of a period.
    repeat (1000) @(negedge clk);
    chk("t5_pre_lp2", int'(lftPWM2), 1);
    chk("t5_pre_rp2", int'(rghtPWM2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_outs", int'({lftPWM1, lftPWM2, rghtPWM1, rghtPWM2}), 0);
    chk("t5_rst_synch", int'(pwm_synch), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hi = 0;
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      hi += int'(lftPWM1 | lftPWM2 | rghtPWM1 | rghtPWM2);
    end
    chk("t5_dead", hi, 0);
    p1l = 0; p2l = 0; p1r = 0;
    for (int k = 34; k < 2048; k++) begin
      @(negedge clk);
      p1l += int'(lftPWM1);
      p2l += int'(lftPWM2);
      p1r += int'(rghtPWM1);
    end
    chk("t5_lp1", p1l, 992);
    chk("t5_lp2", p2l, 990);
    chk("t5_rp1", p1r, 992);
    chk("t5_synch", int'(pwm_synch), 1);

    // Random speeds each period, including endpoint values.
    for (int p = 0; p < 16; p++) begin
      case (p % 4)
        0:       begin lft_spd = 11'h3FF; rght_spd = 11'(($urandom)); end
        1:       begin lft_spd = 11'(($urandom)); rght_spd = 11'h400; end
        default: begin lft_spd = 11'(($urandom)); rght_spd = 11'(($urandom)); end
      endcase
      measure(int'($urandom_range(0, 2046)), 11'(($urandom)),
              p1l, p2l, p1r, p2r, syn);
      chk("t6_synch", syn, 1);
    end
    #1;
    chk("overlap", ovl, 0);
    chk("min_gap_ge_32", int'(min_gap >= 32), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
